// File: rtl/fft_pkg.sv
// Shared constants and state type for the tuner FFT frame sequencer.
package fft_pkg;

  localparam int N_POINTS = 512;
  localparam int ADDR_W   = 9;
  localparam int BIN_W    = 32;
  localparam int SMP_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FFT_GO,
    FFT_WAIT,
    RD_ADDR,
    RD_LAT,
    TX,
    FIN
  } seq_state_t;

endpackage

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller: fills the FFT sample RAM from the I2S receiver,
// kicks the FFT core, then streams every bin word out to the SPI shifter.
module fft_frame_sequencer
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [23:0]       sample_data,
  output logic              smp_we,
  output logic [ADDR_W-1:0] smp_waddr,
  output logic [SMP_W-1:0]  smp_wdata,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [ADDR_W-1:0] bin_raddr,
  input  logic [BIN_W-1:0]  bin_rdata,
  output logic [BIN_W-1:0]  tx_word,
  output logic              tx_load,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [ADDR_W-1:0] bin_cnt_q, bin_cnt_d;
  logic              smp_we_q, smp_we_d;
  logic [ADDR_W-1:0] smp_waddr_q, smp_waddr_d;
  logic [SMP_W-1:0]  smp_wdata_q, smp_wdata_d;
  logic              fft_start_q, fft_start_d;
  logic [BIN_W-1:0]  tx_word_q, tx_word_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  // The low byte of each I2S sample is below the RAM's 16-bit resolution.
  logic unused_sample_lsbs;
  assign unused_sample_lsbs = ^sample_data[7:0];

  // Frame sequencing: state transitions plus the sample and bin counters.
  always_comb begin
    state_d   = state_q;
    smp_cnt_d = smp_cnt_q;
    bin_cnt_d = bin_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = CAPTURE;
          smp_cnt_d = '0;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          if (smp_cnt_q == LAST_IDX) begin
            state_d = FFT_GO;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
      end
      FFT_GO: begin
        state_d = FFT_WAIT;
      end
      FFT_WAIT: begin
        if (fft_done) begin
          state_d   = RD_ADDR;
          bin_cnt_d = '0;
        end
      end
      RD_ADDR: begin
        state_d = RD_LAT;
      end
      RD_LAT: begin
        state_d = TX;
      end
      TX: begin
        if (tx_ready) begin
          if (bin_cnt_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            bin_cnt_d = bin_cnt_q + 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      FIN: begin
        if (enable) begin
          state_d   = CAPTURE;
          smp_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: sample writes, the delayed FFT start, the bin latch
  // and the saturating count of samples that arrive while not capturing.
  always_comb begin
    smp_we_d    = 1'b0;
    smp_waddr_d = smp_waddr_q;
    smp_wdata_d = smp_wdata_q;
    fft_start_d = (state_q == FFT_GO);
    tx_word_d   = tx_word_q;
    drop_cnt_d  = drop_cnt_q;
    if ((state_q == CAPTURE) && sample_valid) begin
      smp_we_d    = 1'b1;
      smp_waddr_d = smp_cnt_q;
      smp_wdata_d = sample_data[23:8];
    end
    if (state_q == RD_LAT) begin
      tx_word_d = bin_rdata;
    end
    if (sample_valid && (state_q != IDLE) && (state_q != CAPTURE) &&
        (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      smp_cnt_q   <= '0;
      bin_cnt_q   <= '0;
      smp_we_q    <= 1'b0;
      smp_waddr_q <= '0;
      smp_wdata_q <= '0;
      fft_start_q <= 1'b0;
      tx_word_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bin_cnt_q   <= bin_cnt_d;
      smp_we_q    <= smp_we_d;
      smp_waddr_q <= smp_waddr_d;
      smp_wdata_q <= smp_wdata_d;
      fft_start_q <= fft_start_d;
      tx_word_q   <= tx_word_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign smp_we    = smp_we_q;
  assign smp_waddr = smp_waddr_q;
  assign smp_wdata = smp_wdata_q;
  assign fft_start = fft_start_q;
  assign bin_raddr = bin_cnt_q;
  assign tx_word   = tx_word_q;
  assign drop_cnt  = drop_cnt_q;
  assign tx_load   = (state_q == TX);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: a cycle-stamped behavioural
// model of a frame is compared against the DUT every cycle, and a few literal
// expectations pin the model down.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;
  import fft_pkg::*;

  localparam int NP = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] sample_data = '0;
  logic        fft_done = 1'b0;
  logic [31:0] bin_rdata = '0;
  logic        tx_ready = 1'b0;
  logic        smp_we;
  logic [8:0]  smp_waddr;
  logic [15:0] smp_wdata;
  logic        fft_start;
  logic [8:0]  bin_raddr;
  logic [31:0] tx_word;
  logic        tx_load;
  logic        busy;
  logic        done;
  logic [7:0]  drop_cnt;

  fft_frame_sequencer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
    .fft_start(fft_start), .fft_done(fft_done),
    .bin_raddr(bin_raddr), .bin_rdata(bin_rdata),
    .tx_word(tx_word), .tx_load(tx_load), .tx_ready(tx_ready),
    .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ram_addr_prev = 0;

  // Observations of DUT behaviour, used by the literal checks.
  int          obs_waddr[$];
  int          obs_wdata[$];
  logic [31:0] obs_words[$];
  int          obs_tcyc[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        prev_load = 1'b0;
  logic [31:0] prev_word = '0;

  // Behavioural model: a frame is a count of collected samples plus the
  // cycle numbers at which each later event is due.
  bit          m_active, m_reading;
  int          m_got, m_start_at, m_bin, m_load_from, m_done_at, m_drops;
  bit          e_we, e_start, e_done, e_load;
  int          e_waddr, e_wdata;
  logic [31:0] e_word;

  function automatic logic [31:0] ram_word(input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    return {a16, ~a16};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_reading = 0; m_got = 0; m_start_at = 32'h3FFF_FFFF;
    m_bin = 0; m_load_from = 0; m_done_at = -1; m_drops = 0;
    e_we = 0; e_start = 0; e_done = 0; e_load = 0;
    e_waddr = 0; e_wdata = 0; e_word = '0;
  endfunction

  // Advance the model over cycle c using the inputs seen during c; the e_*
  // values then describe cycle c+1.
  function automatic void model_step(input int c);
    e_we = 0;
    if (!m_active) begin
      if (enable) begin
        m_active = 1;
        m_got = 0;
      end
    end else if (m_got < NP) begin
      if (sample_valid) begin
        e_we = 1;
        e_waddr = m_got;
        e_wdata = int'(sample_data[23:8]);
        m_got++;
        if (m_got == NP) m_start_at = c + 2;
      end
    end else begin
      if (sample_valid && m_drops < 255) m_drops++;
      if (c == m_done_at) begin
        if (enable) m_got = 0;
        else m_active = 0;
      end else if (!m_reading) begin
        if (c >= m_start_at && fft_done) begin
          m_reading = 1;
          m_bin = 0;
          m_load_from = c + 3;
        end
      end else if (c >= m_load_from && tx_ready) begin
        if (m_bin == NP - 1) begin
          m_reading = 0;
          m_done_at = c + 1;
        end else begin
          m_bin++;
          m_load_from = c + 3;
        end
      end
    end
    e_start = (c + 1 == m_start_at);
    e_done  = (c + 1 == m_done_at);
    e_load  = m_reading && (c + 1 >= m_load_from);
    if (m_reading && (c + 1 == m_load_from)) e_word = ram_word(m_bin);
  endfunction

  // Compare process: step the model at each rising edge, then check all
  // DUT outputs 1 ns later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        model_reset();
        prev_load = 1'b0;
      end else begin
        if (prev_load && tx_ready) begin
          obs_words.push_back(prev_word);
          obs_tcyc.push_back(cyc);
        end
        model_step(cyc);
      end
      cyc++;
      #1;
      checkOutput("smp_we",    32'(smp_we),    32'(e_we));
      checkOutput("smp_waddr", 32'(smp_waddr), 32'(e_waddr));
      checkOutput("smp_wdata", 32'(smp_wdata), 32'(e_wdata));
      checkOutput("fft_start", 32'(fft_start), 32'(e_start));
      checkOutput("bin_raddr", 32'(bin_raddr), 32'(m_bin));
      checkOutput("tx_load",   32'(tx_load),   32'(e_load));
      checkOutput("tx_word",   tx_word,        e_word);
      checkOutput("busy",      32'(busy),      32'(m_active));
      checkOutput("done",      32'(done),      32'(e_done));
      checkOutput("drop_cnt",  32'(drop_cnt),  32'(m_drops));
      prev_load = tx_load;
      prev_word = tx_word;
      if (smp_we) begin
        obs_waddr.push_back(int'(smp_waddr));
        obs_wdata.push_back(int'(smp_wdata));
      end
      if (fft_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // One cycle of stimulus, driven at the falling edge; also models the bin
  // RAM's one-cycle read latency.
  task automatic applyStimulus(input logic en, input logic sv,
                               input logic [23:0] sd, input logic fd,
                               input logic rdy);
    @(negedge clk);
    bin_rdata = ram_word(ram_addr_prev);
    ram_addr_prev = int'(bin_raddr);
    enable = en;
    sample_valid = sv;
    sample_data = sd;
    fft_done = fd;
    tx_ready = rdy;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_flags"}, 32'({smp_we, fft_start, tx_load, busy, done}), 32'd0);
    checkOutput({tag, "_smp_waddr"}, 32'(smp_waddr), 32'd0);
    checkOutput({tag, "_smp_wdata"}, 32'(smp_wdata), 32'd0);
    checkOutput({tag, "_bin_raddr"}, 32'(bin_raddr), 32'd0);
    checkOutput({tag, "_tx_word"}, tx_word, 32'd0);
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  task automatic clearObs();
    obs_waddr.delete();
    obs_wdata.delete();
    obs_words.delete();
    obs_tcyc.delete();
  endtask

  task automatic checkTransfers(input string tag);
    int bad_order;
    int bad_gap;
    checkOutput({tag, "_xfer_count"}, 32'(obs_words.size()), 32'd512);
    if (obs_words.size() == NP) begin
      bad_order = 0;
      for (int i = 0; i < NP; i++) begin
        if (obs_words[i] !== ram_word(i)) bad_order++;
      end
      checkOutput({tag, "_xfer_order_errs"}, 32'(bad_order), 32'd0);
      checkOutput({tag, "_first_word"}, obs_words[0], 32'h0000_FFFF);
      checkOutput({tag, "_last_word"}, obs_words[NP-1], 32'h01FF_FE00);
      checkOutput({tag, "_done_after_last"}, 32'(done_cyc), 32'(obs_tcyc[NP-1] + 1));
      if (tag == "A") begin
        bad_gap = 0;
        for (int i = 1; i < NP; i++) begin
          if (obs_tcyc[i] - obs_tcyc[i-1] != 3) bad_gap++;
        end
        checkOutput({tag, "_xfer_gap_errs"}, 32'(bad_gap), 32'd0);
      end
    end
  endtask

  initial begin
    int d0, s0, n, last_strobe;
    int sent;
    int spurious_at;

    // Reset state
    repeat (3) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    checkAllZero("reset");
    reset_n = 1'b1;

    // Strobes in IDLE are ignored and not counted as drops
    repeat (4) applyStimulus(1'b0, 1'b1, 24'hABCDEF, 1'b0, 1'b1);
    checkOutput("idle_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Frame A: ramp samples, 300 drops during the FFT wait, tx_ready high
    $display("[TB] frame A: ramp capture, saturating drops, tx_ready held");
    clearObs();
    s0 = start_cnt;
    d0 = done_cnt;
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int k = 0; k < NP; k++)
      applyStimulus(1'b1, 1'b1, 24'(32'h200000 + k * 32'h10000), 1'b0, 1'b1);
    last_strobe = cyc;
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'b1, (i < 300), 24'(i), 1'b0, 1'b1);
    checkOutput("A_drop_saturated", 32'(drop_cnt), 32'd255);
    checkOutput("A_write_count", 32'(obs_waddr.size()), 32'd512);
    if (obs_waddr.size() == NP) begin
      checkOutput("A_wdata0", 32'(obs_wdata[0]), 32'h2000);
      checkOutput("A_wdata5", 32'(obs_wdata[5]), 32'h2500);
      checkOutput("A_wdata511", 32'(obs_wdata[511]), 32'h1F00);
      checkOutput("A_waddr511", 32'(obs_waddr[511]), 32'd511);
    end
    checkOutput("A_start_count", 32'(start_cnt - s0), 32'd1);
    checkOutput("A_start_cycle", 32'(start_cyc), 32'(last_strobe + 2));
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("A_done_seen", 32'(done_cnt - d0), 32'd1);
    checkTransfers("A");

    // Frame B: capture resumes straight after FIN; spurious fft_done during
    // capture, random strobes and tx_ready, enable dropped in the FFT wait
    $display("[TB] frame B: random capture, spurious done, random tx_ready");
    clearObs();
    s0 = start_cnt;
    d0 = done_cnt;
    sent = 0;
    n = 0;
    spurious_at = 100;
    while (obs_waddr.size() < NP && n < 4000) begin
      logic sv;
      sv = ($urandom_range(0, 2) != 0);
      applyStimulus(1'b1, sv, 24'($urandom), (sent == spurious_at), 1'($urandom_range(0, 1)));
      if (sv) sent++;
      n++;
    end
    checkOutput("B_first_waddr", 32'(obs_waddr.size() > 0 ? obs_waddr[0] : -1), 32'd0);
    checkOutput("B_write_count", 32'(obs_waddr.size()), 32'd512);
    for (int i = 0; i < 40; i++)
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 24'h0, 1'b0, 1'($urandom_range(0, 1)));
    checkOutput("B_start_count", 32'(start_cnt - s0), 32'd1);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1, 1'b0);
    n = 0;
    while (done_cnt == d0 && n < 8000) begin
      applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    repeat (4) applyStimulus(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("B_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("B_idle_after", 32'(busy), 32'd0);
    checkTransfers("B");

    // Frame C: reset while bin 100 waits in TX
    $display("[TB] frame C: reset mid-readout");
    clearObs();
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int k = 0; k < NP; k++)
      applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b1);
    repeat (10) applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b1, 1'b1);
    n = 0;
    while (obs_words.size() < 100 && n < 1000) begin
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
      n++;
    end
    n = 0;
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
    while (!tx_load && n < 10) begin
      applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b0);
      n++;
    end
    checkOutput("C_waiting_bin", 32'(bin_raddr), 32'd100);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    checkAllZero("C_reset");
    repeat (2) applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    reset_n = 1'b1;
    clearObs();
    applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 1'b1, 24'h123400 + 24'(k), 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b1, 1'b0, 24'h0, 1'b0, 1'b1);
    checkOutput("C_new_writes", 32'(obs_waddr.size()), 32'd5);
    checkOutput("C_restart_addr0", 32'(obs_waddr.size() > 0 ? obs_waddr[0] : -1), 32'd0);
    checkOutput("C_no_done", 32'(done_cnt - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

- Frame-level controller for the tuner FFT path.
- Collects one frame of I2S samples into the FFT sample RAM, starts the FFT core and waits for completion, then streams every output bin word to the SPI transmitter.
- Sits between the I2S receiver, the FFT core / bin RAM and the SPI slave shifter inside `fft_master`, and produces its `done` indication.

## Interface
- `N_POINTS`, 512, samples per frame and bins read out per frame (power of 2)
- `ADDR_W`, 9, log2(N_POINTS)
- `clk` in 1: system clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `enable` in 1: level; permits starting new frames
- `sample_valid` in 1: one-cycle strobe from I2S receiver
- `sample_data` in 24: signed I2S sample, valid with `sample_valid`
- `smp_we` out 1: sample RAM write enable
- `smp_waddr` out ADDR_W: sample RAM write address
- `smp_wdata` out 16: `sample_data[23:8]`
- `fft_start` out 1: one-cycle start pulse to FFT core
- `fft_done` in 1: one-cycle completion pulse from FFT core
- `bin_raddr` out ADDR_W: bin RAM read address, 1-cycle read latency
- `bin_rdata` in 32: bin word {re[15:0], im[15:0]}
- `tx_word` out 32: word to SPI shifter
- `tx_load` out 1: word valid; transfer occurs on `tx_load && tx_ready`
- `tx_ready` in 1: SPI shifter can accept a word
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse after the last bin is accepted
- `drop_cnt` out 8: saturating count of samples dropped outside CAPTURE

## Operation
- States: IDLE, CAPTURE, FFT_GO, FFT_WAIT, RD_ADDR, RD_LAT, TX, FIN.
- IDLE → CAPTURE when `enable`=1. The sample counter clears on entry.
- CAPTURE: each `sample_valid` registers one write.
  - Next cycle: `smp_we`=1, `smp_waddr`=count, `smp_wdata`=`sample_data[23:8]`.
  - The count increments per accepted sample.
  - On accepting sample N_POINTS-1, go to FFT_GO.
- FFT_GO: `fft_start`=1 for exactly one cycle, then FFT_WAIT.
- FFT_WAIT: hold until `fft_done`=1. Go to RD_ADDR with the bin counter at 0.
- RD_ADDR: drive `bin_raddr`=bin counter, then RD_LAT.
- RD_LAT: capture `bin_rdata` into `tx_word` at the end of the cycle, then TX.
- TX: `tx_load`=1 with `tx_word` stable until `tx_ready`=1. On the transfer cycle:
  - If bin counter = N_POINTS-1, go to FIN.
  - Otherwise increment the counter and go to RD_ADDR.
- FIN: `done`=1 for one cycle.
  - Go to CAPTURE if `enable`=1, else IDLE.
- Deasserting `enable` mid-frame does not abort; the current frame completes.
- `sample_valid` in FFT_GO, FFT_WAIT, RD_ADDR, RD_LAT, TX or FIN is dropped.
  - Each drop increments `drop_cnt`, which saturates at 255.
  - `sample_valid` in IDLE is ignored and not counted.
- `fft_done` outside FFT_WAIT is ignored. `tx_ready` outside TX is ignored.
- Counters wrap only through explicit clear. The address never exceeds N_POINTS-1.

## Timing
- Reset (`reset_n`=0, asynchronous): state IDLE.
  - All outputs 0: `smp_we`, `smp_waddr`, `smp_wdata`, `fft_start`, `bin_raddr`, `tx_word`, `tx_load`, `busy`, `done`, `drop_cnt`.
  - Reset mid-frame abandons the frame; no `done` is issued.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.
- `sample_valid` at cycle t → `smp_we` at t+1.
- Last sample at t → last `smp_we` at t+1 → `fft_start` at t+2.
- `fft_done` at t → `bin_raddr` valid at t+1 → `tx_load` high from t+3.
- Per-bin overhead is 3 cycles plus the `tx_ready` wait. `tx_ready` held high gives one word every 3 cycles.
- Last transfer at t → `done` at t+1.
- With `enable` held, CAPTURE resumes at t+2; a sample at t+2 is accepted into address 0.

## Structure
- Package `fft_pkg`: `N_POINTS`, `ADDR_W`, bin word width (32), sample width (16) and the state enum `seq_state_t`.
- Single module; no sub-module. The drop counter and address counters are inline registers.

## Test plan
- Reset mid-TX at bin 100 → all outputs 0 next cycle, no `done`; the next frame starts at `smp_waddr`=0.
- `enable`=1, 512 strobes with `sample_data`=24'h200000+k·24'h010000 →
  - `smp_waddr` runs 0..511 with `smp_wdata`=16'h2000+k·16'h0100 (mod 2^16).
  - Exactly one `fft_start`, two cycles after the last strobe.
- `fft_done` after 1000 cycles, bin RAM model returning word = {addr, ~addr}, `tx_ready` always 1 →
  - 512 transfers in address order, 3 cycles apart.
  - `done` one cycle after the 512th transfer.
- `tx_ready` toggled randomly → `tx_word` stable while `tx_load`=1 && `tx_ready`=0, and no bin lost or duplicated.
- 300 strobes during FFT_WAIT/TX → `drop_cnt`=255 (saturated), and capture of the next frame is unaffected.
- `enable` dropped during FFT_WAIT; spurious `fft_done` during CAPTURE →
  - The frame completes with one `done`, then IDLE.
  - The spurious pulse is ignored; capture still needs 512 samples.
